// File: rtl/ultrasonic_sequencer.sv
// rtl/ultrasonic_sequencer.sv - HC-SR04 trigger, echo timing, timeout and holdoff sequencer
module ultrasonic_sequencer #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo,
  output logic        trigger,
  output logic [31:0] echo_duration,
  output logic        data_valid,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_HIGH,
    MEASURE,
    HOLDOFF
  } state_e;

  localparam logic [31:0] TRIG_LAST    = TRIG_CYCLES - 1;
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;
  localparam logic [31:0] TIMEOUT_MAX  = TIMEOUT_CYCLES;
  localparam logic [31:0] HOLDOFF_LAST = HOLDOFF_CYCLES - 1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dur_q, dur_d;
  logic        dv_q, dv_d;
  logic        to_q, to_d;
  logic        trig_q;
  logic        busy_q;
  logic        echo_meta_q, echo_s_q, echo_p_q;
  logic        rise;

  assign rise = echo_s_q & ~echo_p_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    dv_d    = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_HIGH: begin
        // Only a fresh edge starts a measurement; a stale high level is ignored.
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = 32'd1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      MEASURE: begin
        if (!echo_s_q) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          dur_d   = cnt_q;
          dv_d    = 1'b1;
        end else if (cnt_q == TIMEOUT_MAX) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLDOFF: begin
        // A stuck echo keeps restarting the idle interval.
        if (echo_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == HOLDOFF_LAST) begin
          state_d = enable ? TRIG : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dur_q       <= '0;
      dv_q        <= 1'b0;
      to_q        <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_p_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dur_q       <= dur_d;
      dv_q        <= dv_d;
      to_q        <= to_d;
      trig_q      <= (state_d == TRIG);
      busy_q      <= (state_d != IDLE);
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_p_q    <= echo_s_q;
    end
  end

  assign trigger       = trig_q;
  assign echo_duration = dur_q;
  assign data_valid    = dv_q;
  assign timeout       = to_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ultrasonic_sequencer.sv
// tb/tb_ultrasonic_sequencer.sv - self-checking bench for ultrasonic_sequencer
module tb_ultrasonic_sequencer;

  localparam int T   = 5;
  localparam int TO  = 100;
  localparam int HO  = 20;
  localparam int LEN = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        echo;
  logic        trigger;
  logic [31:0] echo_duration;
  logic        data_valid;
  logic        timeout;
  logic        busy;

  ultrasonic_sequencer #(
    .TRIG_CYCLES   (T),
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .echo         (echo),
    .trigger      (trigger),
    .echo_duration(echo_duration),
    .data_valid   (data_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pin schedule: value driven just after edge n. Expected outputs: value just after edge n.
  bit pin_s[LEN];
  bit en_s[LEN];
  bit exp_trig[LEN];
  bit exp_busy[LEN];
  bit exp_dv[LEN];
  bit exp_to[LEN];
  int dv_val[LEN];
  int exp_dur[LEN];
  int tf_arr[64];
  int st_arr[64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [35:0] outs();
    return {trigger, busy, data_valid, timeout, echo_duration};
  endfunction

  function automatic bit cond(input int sel);
    return (sel == 0) ? trigger : ((sel == 1) ? !trigger : data_valid);
  endfunction

  task automatic wait_cond(input int sel, input int lim, input string nm, output int n);
    n = 0;
    while (!cond(sel) && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 64'(cond(sel)), 64'd1);
  endtask

  // Echo level the sequencer sees when deciding at edge y (two sync stages plus edge register).
  function automatic bit sy(input int y);
    if (y < 3 || y - 3 >= LEN) return 1'b0;
    return pin_s[y-3];
  endfunction

  task automatic put_pulse(input int from, input int w);
    for (int k = from; k < from + w; k++)
      if (k >= 0 && k < LEN) pin_s[k] = 1'b1;
  endtask

  task automatic plan_echo(input int shot, input int tf);
    int kind;
    int d;
    case (shot)
      0: put_pulse(tf + 10, 40);
      1: ;
      2: put_pulse(tf + 5, 150);
      3: begin
        put_pulse(tf + 8, 30);
        for (int k = tf + 23; k < tf + 323 && k < LEN; k++) en_s[k] = 1'b0;
      end
      default: begin
        kind = $urandom_range(0, 9);
        case (kind)
          0: ;
          1: put_pulse(tf + $urandom_range(0, 20), $urandom_range(TO + 1, TO + 40));
          2: put_pulse(tf + $urandom_range(95, 99), $urandom_range(1, 30));
          3: put_pulse(tf + $urandom_range(0, 10), $urandom_range(TO - 1, TO + 1));
          4: begin
            put_pulse(tf - 4, $urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) put_pulse(tf + 20, $urandom_range(1, 40));
          end
          5: begin
            d = $urandom_range(0, 40);
            put_pulse(tf + d, 10);
            put_pulse(tf + d + 20, $urandom_range(1, 15));
          end
          default: put_pulse(tf + $urandom_range(0, 60), $urandom_range(1, 90));
        endcase
      end
    endcase
  endtask

  // Shot-by-shot timeline: trigger window, echo outcome, holdoff end, enable decision.
  task automatic build_model();
    int start, tf, s, e, x, y, run, shot, cur;
    bit live;
    for (int k = 0; k < LEN; k++) begin
      pin_s[k] = 1'b0;  en_s[k] = (k >= 3);
      exp_trig[k] = 1'b0; exp_busy[k] = 1'b0; exp_dv[k] = 1'b0; exp_to[k] = 1'b0;
      dv_val[k] = 0;
    end
    x = 1;
    while (x < LEN && !en_s[x-1]) x++;
    start = x;
    shot  = 0;
    live  = 1'b1;
    while (live) begin
      if (shot < 64) st_arr[shot] = start;
      for (int k = start; k < start + T; k++) exp_trig[k] = 1'b1;
      tf = start + T;
      if (shot < 64) tf_arr[shot] = tf;
      plan_echo(shot, tf);
      s = -1;
      for (int k = 1; k <= TO; k++)
        if (sy(tf + k) && !sy(tf + k - 1)) begin
          s = tf + k;
          break;
        end
      if (s < 0) begin
        e = tf + TO;
        exp_to[e] = 1'b1;
      end else begin
        e = s + TO;
        for (int k = s + 1; k <= s + TO; k++)
          if (!sy(k)) begin
            e = k;
            break;
          end
        if (sy(e)) exp_to[e] = 1'b1;
        else begin
          exp_dv[e] = 1'b1;
          dv_val[e] = e - s;
        end
      end
      y   = e;
      run = 0;
      while (run < HO) begin
        y++;
        if (sy(y)) run = 0;
        else run++;
      end
      for (int k = start; k < y; k++) exp_busy[k] = 1'b1;
      shot++;
      if (y > LEN - 800) begin
        for (int k = y - 1; k < LEN; k++) en_s[k] = 1'b0;
        live = 1'b0;
      end else if (en_s[y-1]) begin
        start = y;
      end else begin
        x = y + 1;
        while (x < LEN && !en_s[x-1]) x++;
        if (x > LEN - 800) begin
          for (int k = y; k < LEN; k++) en_s[k] = 1'b0;
          live = 1'b0;
        end else begin
          start = x;
        end
      end
    end
    cur = 0;
    for (int k = 0; k < LEN; k++) begin
      if (exp_dv[k]) cur = dv_val[k];
      exp_dur[k] = cur;
    end
  endtask

  initial begin
    int n;
    int tf0, tf1, tf2, tf3;
    rst    = 1'b1;
    enable = 1'b1;
    echo   = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 64'(outs()), 64'd0);
    end

    rst  = 1'b0;
    echo = 1'b0;
    wait_cond(0, 10, "b_trig_rise", n);
    chk("b_trig_rise_lat", 64'(n), 64'd1);
    wait_cond(1, 20, "b_trig_fall", n);
    chk("b_trig_width", 64'(n), 64'(T));
    repeat (3) begin @(posedge clk); #1; end
    echo = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    echo = 1'b0;
    wait_cond(2, 50, "b_dv_rise", n);
    chk("b_dv_latency", 64'(n), 64'd3);
    chk("b_dur", 64'(echo_duration), 64'd12);
    wait_cond(0, 100, "b_trig2_rise", n);
    wait_cond(1, 20, "b_trig2_fall", n);
    echo = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("b_rst_mid_measure", 64'(outs()), 64'd0);
    rst  = 1'b0;
    echo = 1'b0;
    @(posedge clk);
    #1;
    chk("b_restart", 64'({trigger, busy, data_valid, timeout}), 64'b1100);

    rst    = 1'b1;
    enable = 1'b0;
    echo   = 1'b0;
    build_model();
    tf0 = tf_arr[0]; tf1 = tf_arr[1]; tf2 = tf_arr[2]; tf3 = tf_arr[3];
    chk("m_shot0_dv",      64'(exp_dv[tf0 + 53]), 64'd1);
    chk("m_shot0_dur",     64'(exp_dur[tf0 + 53]), 64'd40);
    chk("m_shot1_to",      64'(exp_to[tf1 + 100]), 64'd1);
    chk("m_shot1_dur",     64'(exp_dur[tf1 + 100]), 64'd40);
    chk("m_shot2_start",   64'(st_arr[2]), 64'(tf1 + 120));
    chk("m_shot2_to",      64'(exp_to[tf2 + 108]), 64'd1);
    chk("m_shot3_start",   64'(st_arr[3]), 64'(tf2 + 177));
    chk("m_shot3_dv",      64'({exp_dv[tf3 + 41], exp_to[tf3 + 41]}), 64'b10);
    chk("m_shot3_dur",     64'(exp_dur[tf3 + 41]), 64'd30);
    chk("m_shot3_busy",    64'({exp_busy[tf3 + 60], exp_busy[tf3 + 61], exp_trig[tf3 + 61]}), 64'b100);

    for (int k = 0; k < LEN; k++) begin
      @(posedge clk);
      #1;
      rst    = 1'b0;
      echo   = pin_s[k];
      enable = en_s[k];
      @(negedge clk);
      chk($sformatf("cyc%0d", k), 64'(outs()),
          64'({exp_trig[k], exp_busy[k], exp_dv[k], exp_to[k], 32'(exp_dur[k])}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
